// File: rtl/sv_stream_fifo.sv
// Synchronous stream FIFO with valid/ready handshakes on both sides, first-word-fall-through
// output and a synchronous flush. No bypass paths, so minimum latency is one cycle.
`ifndef BUS_WIDTH
`define BUS_WIDTH 8
`endif

module sv_stream_fifo #(
    parameter int bus_width = `BUS_WIDTH,
    parameter int depth     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [bus_width-1:0]     in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [bus_width-1:0]     out_data,
    output logic [$clog2(depth):0]   count
);

    localparam int aw = $clog2(depth);
    localparam int cw = aw + 1;

    logic [bus_width-1:0] mem_q [depth];
    logic [aw-1:0]        wr_ptr_q, wr_ptr_d;
    logic [aw-1:0]        rd_ptr_q, rd_ptr_d;
    logic [cw-1:0]        count_q, count_d;
    logic                 push, pop;

    assign in_ready  = (count_q != cw'(depth)) && !rst;
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + aw'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + aw'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + cw'(1);
                2'b01:   count_d = count_q - cw'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; out_data is only meaningful while out_valid is high.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= in_data;
    end

endmodule

// File: doc/sv_stream_fifo.md
SV_STREAM_FIFO -- requirements
Module: sv_stream_fifo

Interface
REQ-001 Parameter bus_width, default `BUS_WIDTH (8 when undefined), data width of every payload port.
REQ-002 Parameter depth, default 4, entry count; legal values are powers of two, 2..64.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 flush  input  1  synchronous discard of all stored entries.
REQ-006 in_valid  input  1  upstream presents in_data.
REQ-007 in_ready  output  1  FIFO accepts a word this cycle.
REQ-008 in_data  input  bus_width  upstream payload.
REQ-009 out_valid  output  1  out_data holds the oldest stored word.
REQ-010 out_ready  input  1  downstream stage (svModule bus consumer) takes the word.
REQ-011 out_data  output  bus_width  oldest stored word.
REQ-012 count  output  $clog2(depth)+1  number of stored entries, 0..depth.

Function
REQ-013 Push SHALL occur when in_valid && in_ready at a rising edge; pop SHALL occur when out_valid && out_ready.
REQ-014 in_ready SHALL equal (count != depth) && !rst; no combinational path from out_ready to in_ready (no full-bypass).
REQ-015 out_valid SHALL equal (count != 0); no combinational path from in_valid to out_valid (no empty-bypass).
REQ-016 Latency: a word pushed at edge N SHALL appear on out_data with out_valid=1 after edge N when the FIFO was empty; one-cycle minimum latency.
REQ-017 out_data SHALL be the entry at the read pointer (first-word-fall-through) and SHALL remain stable while out_valid && !out_ready.
REQ-018 Write and read pointers SHALL be $clog2(depth) bits and wrap modulo depth.
REQ-019 count update: push only +1; pop only -1; push and pop together unchanged; neither unchanged.
REQ-020 Full (count=depth): in_ready=0; a simultaneous pop SHALL reduce count to depth-1 and in_ready SHALL rise the following cycle.
REQ-021 Empty (count=0): out_valid=0; out_ready SHALL be ignored; a push SHALL give count=1.
REQ-022 Order SHALL be strictly FIFO; no word is duplicated or lost across pointer wrap.
REQ-023 flush=1 SHALL, at the next edge, set both pointers and count to 0, overriding any concurrent push or pop; the pushed word is discarded.
REQ-024 Storage array contents need not be reset; out_data is don't-care while out_valid=0.

Reset
REQ-025 rst=1 SHALL immediately (without a clock) force count=0, pointers=0, out_valid=0, in_ready=0.
REQ-026 After rst deasserts, in_ready SHALL be 1 in the first cycle; a reset mid-transfer SHALL discard all stored words, including any being popped.

Verification
REQ-027 Reset then push 0x11,0x22,0x33 on consecutive edges with out_ready=0 -> count 1,2,3; out_data=0x11 from the cycle after the first push.
REQ-028 depth=4: push 0xA0..0xA3 -> count=4, in_ready=0; hold in_valid with 0xA4 and pulse out_ready once -> 0xA0 popped, count=3; 0xA4 accepted next cycle, count=4.
REQ-029 Continuous push and pop 10 words 0x00..0x09 with out_ready=1 -> output sequence 0x00..0x09 in order, count steady at 1, pointers wrap twice.
REQ-030 count=2, assert flush together with in_valid=1 (0x55) -> count=0, out_valid=0 next cycle; 0x55 never appears on out_data.
REQ-031 count=3, assert rst asynchronously mid-cycle -> out_valid, in_ready, count drop to 0 before the next edge; after release, first push 0x77 appears first on out_data.
REQ-032 out_valid=1, out_ready=0 for 5 cycles while pushing -> out_data constant at the oldest word throughout.
